seq_packet_builder: RTL and testbench

- Transmit-side counterpart of the stream packet parser. Accepts one payload of up to 37 bytes, tagged with a 16-bit stream id.
- Assigns the next per-stream sequence number and serializes the packet onto a 32-bit valid/ready word stream with a last flag.
- Sits between payload sources and the link. Its word stream is bit-exact what the parser consumes.

---
 rtl/seq_packet_builder_if.sv | 37 +++
 rtl/seq_packet_builder.sv | 127 ++++++++++++
 tb/tb_seq_packet_builder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_packet_builder_if.sv
// Payload-in / word-out bundle for seq_packet_builder.
// PKT_SEQ_SKIP_EN adds the seqSkip request field.
interface seq_packet_builder_if #(
    parameter int MAX_BYTES = 37
);
    logic [0:8*MAX_BYTES-1] payloadIn;
    logic [5:0]             payloadLen;
    logic [15:0]            streamId;
    logic                   payloadIn_val;
    logic                   payloadIn_ready;
    logic [31:0]            dataOut;
    logic                   dataOut_val;
    logic                   dataOut_ready;
    logic                   dataOut_last;
    logic                   dropErr;
`ifdef PKT_SEQ_SKIP_EN
    logic                   seqSkip;

    modport master (
        output payloadIn, payloadLen, streamId, payloadIn_val, seqSkip, dataOut_ready,
        input  payloadIn_ready, dataOut, dataOut_val, dataOut_last, dropErr
    );
    modport slave (
        input  payloadIn, payloadLen, streamId, payloadIn_val, seqSkip, dataOut_ready,
        output payloadIn_ready, dataOut, dataOut_val, dataOut_last, dropErr
    );
`else
    modport master (
        output payloadIn, payloadLen, streamId, payloadIn_val, dataOut_ready,
        input  payloadIn_ready, dataOut, dataOut_val, dataOut_last, dropErr
    );
    modport slave (
        input  payloadIn, payloadLen, streamId, payloadIn_val, dataOut_ready,
        output payloadIn_ready, dataOut, dataOut_val, dataOut_last, dropErr
    );
`endif
endinterface

// File: rtl/seq_packet_builder.sv
// Builds a sequenced packet (2 header words + payload words) from one payload request.
// Optional PKT_SEQ_SKIP_EN: seqSkip input advances the stream counter by 2 instead of 1.
module seq_packet_builder #(
    parameter int MAX_BYTES   = 37,
    parameter int NUM_STREAMS = 32
) (
    input  logic                  clk,
    input  logic                  reset_b,
    seq_packet_builder_if.slave   bus
);
    localparam int MAX_WORDS = (MAX_BYTES + 3) / 4;
    localparam int PAD_BITS  = 32 * MAX_WORDS;
    localparam int IDX_W     = $clog2(NUM_STREAMS);
    localparam int WI_W      = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;

    state_t              state, state_nxt;
    logic [31:0]         seqs [NUM_STREAMS];
    logic [0:PAD_BITS-1] cap_payload, masked;
    logic [5:0]          cap_len;
    logic [31:0]         cap_seq, seq_new;
    logic [WI_W-1:0]     word_idx, word_idx_nxt, nwords;
    logic [31:0]         out_q, out_nxt, cur_word;
    logic                val_q, val_nxt, last_q, last_nxt, drop_q, ready_q;
    logic                accept, drop, fire, legal;
    logic [15:0]         tot_len;
    logic [IDX_W-1:0]    idx;

    assign idx     = bus.streamId[IDX_W-1:0];
    assign legal   = (bus.payloadLen != 6'd0) && (bus.payloadLen <= 6'(MAX_BYTES));
    assign tot_len = 16'(bus.payloadLen) + 16'd8;
    assign fire    = val_q & bus.dataOut_ready;
    assign nwords  = WI_W'((cap_len + 6'd3) >> 2);
    assign cur_word = cap_payload[{word_idx, 5'd0} +: 32];

`ifdef PKT_SEQ_SKIP_EN
    assign seq_new = seqs[idx] + (bus.seqSkip ? 32'd2 : 32'd1);
`else
    assign seq_new = seqs[idx] + 32'd1;
`endif

    // Bytes past payloadLen are zeroed at capture so data words need no masking.
    always_comb begin
        masked = '0;
        for (int k = 0; k < MAX_BYTES; k++)
            if (k < int'(bus.payloadLen)) masked[8*k +: 8] = bus.payloadIn[8*k +: 8];
    end

    always_comb begin
        state_nxt    = state;
        out_nxt      = out_q;
        val_nxt      = val_q;
        last_nxt     = last_q;
        word_idx_nxt = word_idx;
        accept       = 1'b0;
        drop         = 1'b0;
        case (state)
            IDLE: if (bus.payloadIn_val && ready_q) begin
                if (legal) begin
                    accept       = 1'b1;
                    state_nxt    = HDR0;
                    out_nxt      = {tot_len[7:0], tot_len[15:8], bus.streamId[7:0], bus.streamId[15:8]};
                    val_nxt      = 1'b1;
                    last_nxt     = 1'b0;
                    word_idx_nxt = '0;
                end else begin
                    drop = 1'b1;
                end
            end
            HDR0: if (fire) begin
                state_nxt = HDR1;
                out_nxt   = {cap_seq[7:0], cap_seq[15:8], cap_seq[23:16], cap_seq[31:24]};
            end
            HDR1, DATA: if (fire) begin
                if (last_q) begin
                    state_nxt = IDLE;
                    out_nxt   = '0;
                    val_nxt   = 1'b0;
                    last_nxt  = 1'b0;
                end else begin
                    state_nxt    = DATA;
                    out_nxt      = cur_word;
                    last_nxt     = (word_idx == nwords - 1'b1);
                    word_idx_nxt = word_idx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state       <= IDLE;
            for (int i = 0; i < NUM_STREAMS; i++) seqs[i] <= '0;
            cap_payload <= '0;
            cap_len     <= '0;
            cap_seq     <= '0;
            word_idx    <= '0;
            out_q       <= '0;
            val_q       <= 1'b0;
            last_q      <= 1'b0;
            drop_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            word_idx <= word_idx_nxt;
            out_q    <= out_nxt;
            val_q    <= val_nxt;
            last_q   <= last_nxt;
            drop_q   <= drop;
            ready_q  <= (state_nxt == IDLE);
            if (accept) begin
                cap_payload <= masked;
                cap_len     <= bus.payloadLen;
                cap_seq     <= seq_new;
                seqs[idx]   <= seq_new;
            end
        end
    end

    assign bus.payloadIn_ready = ready_q;
    assign bus.dataOut         = out_q;
    assign bus.dataOut_val     = val_q;
    assign bus.dataOut_last    = last_q;
    assign bus.dropErr         = drop_q;
endmodule

// File: tb/tb_seq_packet_builder.sv
// Randomized and directed bench for seq_packet_builder against a packet-level reference model.
module tb_seq_packet_builder;
    localparam int MB = 37;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    seq_packet_builder_if #(.MAX_BYTES(MB)) bus();
    seq_packet_builder #(.MAX_BYTES(MB), .NUM_STREAMS(32)) dut (
        .clk(clk), .reset_b(reset_b), .bus(bus)
    );

    int checks = 0, errors = 0;
    logic [31:0] mseq [32];
    logic [31:0] exp_q[$];
    logic [31:0] log_w[$];
    bit          log_l[$];
    bit          primed = 0, drop_exp = 0;
    int          drop_seen = 0;
    int          rdy_mode = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: whole packets are expanded into an expected word queue at acceptance.
    task automatic model_accept();
        logic [15:0] id, l;
        logic [31:0] s, w;
        int len;
        id  = bus.streamId;
        len = int'(bus.payloadLen);
        l   = 16'(len + 8);
`ifdef PKT_SEQ_SKIP_EN
        mseq[id[4:0]] = mseq[id[4:0]] + (bus.seqSkip ? 32'd2 : 32'd1);
`else
        mseq[id[4:0]] = mseq[id[4:0]] + 32'd1;
`endif
        s = mseq[id[4:0]];
        exp_q.push_back({l[7:0], l[15:8], id[7:0], id[15:8]});
        exp_q.push_back({s[7:0], s[15:8], s[23:16], s[31:24]});
        for (int i = 0; i < (len + 3) / 4; i++) begin
            w = '0;
            for (int j = 0; j < 4; j++)
                if (4*i + j < len) w[31-8*j -: 8] = bus.payloadIn[8*(4*i+j) +: 8];
            exp_q.push_back(w);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!reset_b) begin
            chk("rst_ready", 64'(bus.payloadIn_ready), 0);
            chk("rst_val",   64'(bus.dataOut_val), 0);
            chk("rst_data",  64'(bus.dataOut), 0);
            chk("rst_last",  64'(bus.dataOut_last), 0);
            chk("rst_drop",  64'(bus.dropErr), 0);
            exp_q.delete();
            for (int i = 0; i < 32; i++) mseq[i] = '0;
            primed   = 0;
            drop_exp = 0;
        end else begin
            chk("ready",   64'(bus.payloadIn_ready), 64'(primed && exp_q.size() == 0));
            chk("dropErr", 64'(bus.dropErr), 64'(drop_exp));
            if (bus.dropErr) drop_seen++;
            chk("val",  64'(bus.dataOut_val), 64'(exp_q.size() != 0));
            chk("data", 64'(bus.dataOut), 64'(exp_q.size() != 0 ? exp_q[0] : 32'h0));
            chk("last", 64'(bus.dataOut_last), 64'(exp_q.size() == 1));
            drop_exp = 0;
            if (exp_q.size() != 0) begin
                if (bus.dataOut_ready) begin
                    log_w.push_back(bus.dataOut);
                    log_l.push_back(bus.dataOut_last);
                    void'(exp_q.pop_front());
                end
            end else if (primed && bus.payloadIn_val) begin
                if (bus.payloadLen == 0 || int'(bus.payloadLen) > MB) drop_exp = 1;
                else model_accept();
            end
            primed = 1;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rdy_mode == 0)      bus.dataOut_ready = 1'b1;
        else if (rdy_mode == 1) bus.dataOut_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic send(input logic [15:0] id, input int len, input logic [7:0] base);
        logic [0:8*MB-1] p;
        bit ok;
        for (int k = 0; k < MB; k++) p[8*k +: 8] = (k < len) ? 8'(base + 8'(k)) : 8'($urandom);
        bus.payloadIn     = p;
        bus.payloadLen    = 6'(len);
        bus.streamId      = id;
        bus.payloadIn_val = 1'b1;
        ok = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (bus.payloadIn_ready) ok = 1;
        end
        @(posedge clk); #1;
        bus.payloadIn_val = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            if (bus.payloadIn_ready) ok = 1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        log_w.delete();
        log_l.delete();
    endtask

    initial begin
        int d0;
        bus.payloadIn     = '0;
        bus.payloadLen    = '0;
        bus.streamId      = '0;
        bus.payloadIn_val = 1'b0;
        bus.dataOut_ready = 1'b1;
`ifdef PKT_SEQ_SKIP_EN
        bus.seqSkip       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset_b = 1'b1;

        // Basic 5-byte packet
        clear_log();
        send(16'h0003, 5, 8'h11);
        wait_idle();
        chk("t1_count", 64'(log_w.size()), 4);
        if (log_w.size() == 4) begin
            chk("t1_w0", 64'(log_w[0]), 64'h0D000300);
            chk("t1_w1", 64'(log_w[1]), 64'h01000000);
            chk("t1_w2", 64'(log_w[2]), 64'h11121314);
            chk("t1_w3", 64'(log_w[3]), 64'h15000000);
            chk("t1_lastflags", 64'({log_l[0], log_l[1], log_l[2], log_l[3]}), 64'b0001);
        end

        // Max-length packets on one stream
        for (int p = 0; p < 3; p++) begin
            clear_log();
            send(16'h0007, 37, 8'h01);
            wait_idle();
            chk("t2_count", 64'(log_w.size()), 12);
            if (log_w.size() == 12) begin
                chk("t2_hdr0", 64'(log_w[0]), 64'h2D000700);
                chk("t2_seq",  64'(log_w[1]), 64'({8'(p + 1), 24'h0}));
                chk("t2_tail", 64'(log_w[11]), 64'h25000000);
                chk("t2_last", 64'(log_l[11]), 1);
            end
        end

        // Shared counter index
        begin
            logic [15:0] ids [3];
            logic [31:0] sq  [3];
            ids = '{16'h0001, 16'h0002, 16'h0021};
            sq  = '{32'h01000000, 32'h01000000, 32'h02000000};
            for (int i = 0; i < 3; i++) begin
                clear_log();
                send(ids[i], 4, 8'hA0);
                wait_idle();
                chk("t3_count", 64'(log_w.size()), 3);
                if (log_w.size() == 3) chk("t3_seq", 64'(log_w[1]), 64'(sq[i]));
            end
        end

        // Stalled sink
        rdy_mode = 1;
        clear_log();
        send(16'h0009, 9, 8'h50);
        wait_idle();
        rdy_mode = 0;
        chk("t4_count", 64'(log_w.size()), 5);
        if (log_w.size() == 5) chk("t4_tail", 64'(log_w[4]), 64'h58000000);

        // Illegal lengths are dropped
        clear_log();
        d0 = drop_seen;
        send(16'h000A, 0, 8'h00);
        send(16'h000A, 40, 8'h00);
        repeat (2) @(posedge clk); #1;
        chk("t5_drops", 64'(drop_seen - d0), 2);
        chk("t5_nowords", 64'(log_w.size()), 0);
        send(16'h000A, 2, 8'h77);
        wait_idle();
        if (log_w.size() == 3) chk("t5_seq", 64'(log_w[1]), 64'h01000000);
        else chk("t5_count", 64'(log_w.size()), 3);

        // Reset while HDR1 is presented
        rdy_mode = 2;
        bus.dataOut_ready = 1'b0;
        send(16'h000B, 8, 8'h30);
        bus.dataOut_ready = 1'b1;
        @(posedge clk); #1;
        bus.dataOut_ready = 1'b0;
        chk("t6_hdr1", 64'(bus.dataOut), 64'h01000000);
        reset_b = 1'b0;
        #1;
        chk("t6_rst_val",  64'(bus.dataOut_val), 0);
        chk("t6_rst_data", 64'(bus.dataOut), 0);
        chk("t6_rst_last", 64'(bus.dataOut_last), 0);
        @(posedge clk); #1;
        reset_b = 1'b1;
        rdy_mode = 0;
        bus.dataOut_ready = 1'b1;
        clear_log();
        send(16'h000B, 4, 8'h40);
        wait_idle();
        chk("t6_count", 64'(log_w.size()), 3);
        if (log_w.size() == 3) begin
            chk("t6_seq",  64'(log_w[1]), 64'h01000000);
            chk("t6_data", 64'(log_w[2]), 64'h40414243);
            chk("t6_last", 64'(log_l[2]), 1);
        end

        // Random traffic, checked cycle by cycle by the monitor
        for (int n = 0; n < 60; n++) begin
            int len;
            logic [15:0] id;
            rdy_mode = $urandom_range(0, 1);
            id  = 16'($urandom_range(0, 3) * 32 + $urandom_range(0, 3));
            len = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(38, 63))
                                              : $urandom_range(1, 37);
`ifdef PKT_SEQ_SKIP_EN
            bus.seqSkip = 1'($urandom_range(0, 1));
`endif
            send(id, len, 8'($urandom));
            wait_idle();
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
